// File: rtl/vslc_board_pkg.sv
// Shared defaults and types for the VSLC board I/O conditioner.
package vslc_board_pkg;

  localparam int DEF_DEBOUNCE = 16;
  localparam int DEF_POR      = 8;
  localparam int DEF_SYNC     = 2;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

endpackage

// File: rtl/vslc_btn_debounce.sv
// One button channel: synchroniser chain, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
module vslc_btn_debounce
  import vslc_board_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_out != level_q) begin
      // The edge that would have been the DEBOUNCE_CYCLES-th disagreement accepts the level.
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/vslc_board_io.sv
// Board I/O conditioner: debounced buttons, stretched button-overridable core
// reset, and LED polarity correction.
module vslc_board_io
  import vslc_board_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter logic [N_BTN-1:0] BTN_INV         = N_BTN'(4'b0001),
  parameter int               SYNC_STAGES     = DEF_SYNC,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int               POR_CYCLES      = DEF_POR,
  parameter bit               RST_BTN_EN      = 1'b1,
  parameter int               RST_BTN         = 0,
  parameter int               N_LED           = 8,
  parameter logic [N_LED-1:0] LED_INV         = N_LED'(8'h60)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_pad,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             core_rst_n,
  output logic             por_done,
  input  logic [N_LED-1:0] led,
  output logic [N_LED-1:0] led_pad
);

  localparam int            POR_W    = $clog2(POR_CYCLES + 1);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

  logic [N_BTN-1:0] btn_raw;
  rst_state_e       state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic             core_rst_n_q;
  logic             rst_btn_held;

  assign btn_raw = btn_pad ^ BTN_INV;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    vslc_btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .rise_o (btn_rise[i]),
      .fall_o (btn_fall[i])
    );
  end

  assign rst_btn_held = RST_BTN_EN && btn_level[RST_BTN];

  // A held reset button pins the stretch counter at zero, so the full
  // POR_CYCLES stretch always starts from the button's release.
  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    unique case (state_q)
      HOLD: begin
        if (rst_btn_held) begin
          por_cnt_d = '0;
        end else if (por_cnt_q == POR_LAST) begin
          state_d   = RUN;
          por_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (rst_btn_held) begin
          state_d   = HOLD;
          por_cnt_d = '0;
        end
      end
      default: begin
        state_d   = HOLD;
        por_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      por_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      core_rst_n_q <= (state_d == RUN);
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign por_done   = (state_q == RUN);
  assign led_pad    = led ^ LED_INV;

endmodule

// File: doc/vslc_board_io.md
# vslc_board_io

Parametrised board-level I/O conditioner between the FPGA pads and the VSLC core. It generates a stretched, button-overridable core reset from the asynchronous board reset. It synchronises and debounces N push-buttons into clean levels with one-cycle rise/fall pulses, and applies per-bit polarity to LED outputs. It replaces ad-hoc reset counters and raw button wiring in per-board top levels.

## Interface
Parameters:
- N_BTN, 4, number of button channels (1..16)
- BTN_INV, 4'b0001, per-channel mask; 1 = pad is active-low and is inverted before synchronisation
- SYNC_STAGES, 2, synchroniser flops per channel (2..4)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new level (≥1)
- POR_CYCLES, 8, core reset stretch after release (≥1)
- RST_BTN_EN, 1, 1 = button RST_BTN forces core reset while pressed
- RST_BTN, 0, channel index used as reset button
- N_LED, 8, LED channels
- LED_INV, 8'h60, per-LED mask; 1 = pad is active-low

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_pad  in  N_BTN  raw button pads
- btn_level  out  N_BTN  debounced level, 1 = pressed
- btn_rise  out  N_BTN  one-cycle pulse on accepted press
- btn_fall  out  N_BTN  one-cycle pulse on accepted release
- core_rst_n  out  1  registered active-low reset to the core
- por_done  out  1  high while the reset sequencer is in RUN
- led  in  N_LED  logical LED state, 1 = lit
- led_pad  out  N_LED  led ^ LED_INV, combinational

## Operation
- **Polarity:** raw = btn_pad ^ BTN_INV[N_BTN-1:0]. This feeds a SYNC_STAGES flop chain.
- **Debounce, per channel:**
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If sync_out == btn_level: counter cleared.
  - Else: counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles and the counter clears.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never reaches btn_level.
- **Edges:** btn_rise/btn_fall are registered and asserted in the same cycle btn_level changes. They are never both high on one channel.
- **Reset sequencer:** two states, HOLD and RUN.
  - HOLD: core_rst_n=0, por_done=0. The counter counts from 0. At count POR_CYCLES-1 → RUN.
  - RUN: core_rst_n=1, por_done=1. If RST_BTN_EN && btn_level[RST_BTN] → HOLD, with the counter cleared.
  - In HOLD, if the reset button is still held, the counter stays at 0. Counting resumes only after release.
- **LEDs:** led_pad is pure XOR; there is no register.

## Timing
- **Reset values (rst_n=0):**
  - sync chains, btn_level, btn_rise, btn_fall, and debounce counters all 0
  - state HOLD, core_rst_n=0, por_done=0
- **Release:** core_rst_n rises exactly POR_CYCLES clock edges after the first edge with rst_n=1.
- **Button latency:** a clean pad step gives btn_level change and edge pulse SYNC_STAGES+DEBOUNCE_CYCLES edges later.
- **Reset button:**
  - core_rst_n falls 1 edge after btn_level[RST_BTN] rises.
  - It rises POR_CYCLES edges after btn_level[RST_BTN] falls.
  - The button's own rise/fall pulses are still produced.
- **rst_n asserted mid-debounce or mid-RUN:** everything returns to reset values immediately (asynchronous). No edge pulse is emitted on re-release.
- **Pad pressed at reset release:** treated as a new press. btn_rise fires after the full latency; with the reset button, core_rst_n stays low until release + POR_CYCLES.
- **Simultaneous channels:** channels are fully independent. Multiple pulses may fire in one cycle.

## Structure
- Package vslc_board_pkg holds:
  - default parameter constants: DEF_DEBOUNCE, DEF_POR, DEF_SYNC
  - reset state enum: HOLD, RUN
- Sub-module vslc_btn_debounce (one channel: sync chain, counter, level, rise/fall) is instantiated N_BTN times via generate.
- The sequencer and LED XOR stay in the top module.

## Test plan
- **Reset release, POR_CYCLES=8, no buttons:** core_rst_n=0 for edges 1–7, 1 at edge 8; por_done tracks it; all btn outputs stay 0.
- **Clean press then release, channel 2, DEBOUNCE_CYCLES=4, SYNC_STAGES=2:**
  - btn_rise[2] pulses once 6 edges after the press; btn_level[2]=1.
  - btn_fall[2] pulses once 6 edges after the release.
- **Bounce, channel 1, pad toggling every 2 cycles for 20 cycles, then stable high:** exactly one btn_rise[1], 6 edges after the final stable transition; no btn_fall.
- **Active-low channel 0 (BTN_INV bit 0), pad driven 0 for 30 cycles with RST_BTN_EN=1:**
  - btn_rise[0] fires.
  - core_rst_n falls next edge and stays low while held.
  - After pad returns to 1, core_rst_n rises 6+8 edges after the pad edge.
- **rst_n pulsed low for 1 cycle while a channel's counter is at 3 of 4:** all outputs 0 immediately; no pulse emitted; POR sequence restarts from 0.
- **led=8'hFF with LED_INV=8'h60:** led_pad=8'h9F in the same cycle. led=8'h00 gives led_pad=8'h60.
